// File: rtl/uart_tx_msg_arbiter.sv
// Round-robin, message-locked sharing of one UART TX byte stream; one bubble cycle per message for arbitration.
// Once locked the datapath is combinational: tx_ready goes straight to the owner and a stall watchdog can force release.
module uart_tx_msg_arbiter #(
  parameter int N_CLIENTS      = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic [N_CLIENTS-1:0]          i_req_valid,
  input  logic [N_CLIENTS*DATA_W-1:0]   i_req_data,
  input  logic [N_CLIENTS-1:0]          i_req_last,
  output logic [N_CLIENTS-1:0]          o_req_ready,
  output logic                          o_tx_valid,
  output logic [DATA_W-1:0]             o_tx_data,
  input  logic                          i_tx_ready,
  output logic [N_CLIENTS-1:0]          o_grant,
  output logic                          o_busy,
  output logic                          o_timeout_pulse,
  output logic [((N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1)-1:0] o_timeout_id
);

  localparam int IDW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int SCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [SCW-1:0] STALL_LAST = (TIMEOUT_CYCLES > 0) ? SCW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [SCW-1:0] STALL_MAX  = '1;
  localparam logic [IDW-1:0] LAST_ID    = IDW'(N_CLIENTS - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t               state;
  logic [N_CLIENTS-1:0] grant;
  logic [IDW-1:0]       g_idx;
  logic [IDW-1:0]       rr_ptr;
  logic [SCW-1:0]       stall_cnt;
  logic                 timeout_pulse;
  logic [IDW-1:0]       timeout_id;

  logic                 pick_vld;
  logic [IDW-1:0]       pick_idx;
  logic [N_CLIENTS-1:0] pick_oh;
  logic [IDW-1:0]       next_ptr;
  logic                 locked;
  logic                 g_valid;
  logic                 g_last;
  logic                 tx_xfer;
  logic                 stall_expire;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_CLIENTS) sum = sum - N_CLIENTS;
    return IDW'(sum);
  endfunction

  // Scan downward so the requester closest to rr_ptr is the last one written and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int s = N_CLIENTS - 1; s >= 0; s--) begin
      if (i_req_valid[wrap_add(rr_ptr, s)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(rr_ptr, s);
      end
    end
    pick_oh = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  assign locked       = (state == LOCKED);
  assign g_valid      = i_req_valid[g_idx];
  assign g_last       = i_req_last[g_idx];
  assign tx_xfer      = locked & g_valid & i_tx_ready;
  assign next_ptr     = (g_idx == LAST_ID) ? '0 : g_idx + 1'b1;
  assign stall_expire = (TIMEOUT_CYCLES > 0) && locked && !g_valid && (stall_cnt == STALL_LAST);

  assign o_tx_valid      = locked & g_valid;
  assign o_tx_data       = locked ? i_req_data[g_idx*DATA_W +: DATA_W] : '0;
  assign o_req_ready     = locked ? (grant & {N_CLIENTS{i_tx_ready}}) : '0;
  assign o_grant         = grant;
  assign o_busy          = locked;
  assign o_timeout_pulse = timeout_pulse;
  assign o_timeout_id    = timeout_id;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state         <= IDLE;
      grant         <= '0;
      g_idx         <= '0;
      rr_ptr        <= '0;
      stall_cnt     <= '0;
      timeout_pulse <= 1'b0;
      timeout_id    <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (pick_vld) begin
            state <= LOCKED;
            g_idx <= pick_idx;
            grant <= pick_oh;
          end
        end
        LOCKED: begin
          if (tx_xfer && g_last) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= next_ptr;
            stall_cnt <= '0;
          end else if (g_valid) begin
            // Backpressure with valid held is progress, not a stall.
            stall_cnt <= '0;
          end else if (stall_expire) begin
            state         <= IDLE;
            grant         <= '0;
            rr_ptr        <= next_ptr;
            stall_cnt     <= '0;
            timeout_pulse <= 1'b1;
            timeout_id    <= g_idx;
          end else if ((TIMEOUT_CYCLES > 0) && (stall_cnt != STALL_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_msg_arbiter.sv
// Bench for uart_tx_msg_arbiter: queue-fed clients, a per-cycle message-level reference model, and directed scenarios.
module tb_uart_tx_msg_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            i_clk = 1'b0;
  logic            i_nrst;
  logic [N-1:0]    i_req_valid;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    i_req_last;
  logic [N-1:0]    o_req_ready;
  logic            o_tx_valid;
  logic [DW-1:0]   o_tx_data;
  logic            i_tx_ready;
  logic [N-1:0]    o_grant;
  logic            o_busy;
  logic            o_timeout_pulse;
  logic [1:0]      o_timeout_id;

  uart_tx_msg_arbiter #(.N_CLIENTS(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_last(i_req_last),
    .o_req_ready(o_req_ready), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
    .i_tx_ready(i_tx_ready), .o_grant(o_grant), .o_busy(o_busy),
    .o_timeout_pulse(o_timeout_pulse), .o_timeout_id(o_timeout_id)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Per-client pending bytes {last, data}; the head is what the client presents.
  logic [DW:0] cq [N][$];
  logic [N-1:0] pop;
  int rdy_mode = 0;
  bit rdy_val = 1'b1;

  // Reference model state: owner index (-1 idle), round-robin pointer, stall run length.
  int m_owner = -1;
  int m_rr = 0;
  int m_stall = 0;
  bit m_pulse = 1'b0;
  int m_tid = 0;
  int g, next_owner;
  bit next_pulse;
  logic [N-1:0] exp_grant, exp_rdy;

  int xf_cyc [$];
  int xf_cli [$];
  logic [DW-1:0] xf_dat [$];
  logic [N-1:0] xf_gnt [$];
  int pulse_cyc [$];

  initial begin : engine
    pop = '0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (!i_nrst) begin
        m_owner = -1; m_rr = 0; m_stall = 0; m_pulse = 1'b0; m_tid = 0; pop = '0;
        n_cmp++;
        if ({o_req_ready, o_tx_valid, o_tx_data, o_grant, o_busy, o_timeout_pulse, o_timeout_id} !== '0) begin
          n_bad++;
          $display("FAIL in_reset cyc=%0d ready=%b tx_valid=%b data=%h grant=%b busy=%b pulse=%b id=%0d, required all zero",
                   cyc, o_req_ready, o_tx_valid, o_tx_data, o_grant, o_busy, o_timeout_pulse, o_timeout_id);
        end
      end else begin
        exp_grant = (m_owner < 0) ? '0 : ({{(N-1){1'b0}}, 1'b1} << m_owner);
        n_cmp++;
        if (o_grant !== exp_grant || o_busy !== (m_owner >= 0)) begin
          n_bad++;
          $display("FAIL grant cyc=%0d got grant=%b busy=%b, required grant=%b busy=%b",
                   cyc, o_grant, o_busy, exp_grant, m_owner >= 0);
        end
        n_cmp++;
        if (o_timeout_pulse !== m_pulse || o_timeout_id !== m_tid[1:0]) begin
          n_bad++;
          $display("FAIL timeout_out cyc=%0d got pulse=%b id=%0d, required pulse=%b id=%0d",
                   cyc, o_timeout_pulse, o_timeout_id, m_pulse, m_tid);
        end
        next_owner = m_owner;
        next_pulse = 1'b0;
        if (m_owner < 0) begin
          n_cmp++;
          if (o_tx_valid !== 1'b0 || o_req_ready !== '0) begin
            n_bad++;
            $display("FAIL idle_quiet cyc=%0d got tx_valid=%b ready=%b, required 0", cyc, o_tx_valid, o_req_ready);
          end
          for (int s = 0; s < N; s++) begin
            if (next_owner < 0 && i_req_valid[(m_rr + s) % N]) next_owner = (m_rr + s) % N;
          end
          m_stall = 0;
        end else begin
          g = m_owner;
          exp_rdy = i_tx_ready ? ({{(N-1){1'b0}}, 1'b1} << g) : '0;
          n_cmp++;
          if (o_tx_valid !== i_req_valid[g] || o_req_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL handshake cyc=%0d got tx_valid=%b ready=%b, required tx_valid=%b ready=%b",
                     cyc, o_tx_valid, o_req_ready, i_req_valid[g], exp_rdy);
          end
          if (i_req_valid[g]) begin
            n_cmp++;
            if (o_tx_data !== cq[g][0][DW-1:0]) begin
              n_bad++;
              $display("FAIL tx_data cyc=%0d client=%0d got=%h required=%h", cyc, g, o_tx_data, cq[g][0][DW-1:0]);
            end
            m_stall = 0;
            if (i_tx_ready) begin
              pop[g] = 1'b1;
              xf_cyc.push_back(cyc);
              xf_cli.push_back(g);
              xf_dat.push_back(o_tx_data);
              xf_gnt.push_back(o_grant);
              if (cq[g][0][DW]) begin
                next_owner = -1;
                m_rr = (g + 1) % N;
              end
            end
          end else if (m_stall == TO - 1) begin
            next_owner = -1;
            m_rr = (g + 1) % N;
            next_pulse = 1'b1;
            m_tid = g;
            pulse_cyc.push_back(cyc + 1);
          end else begin
            m_stall++;
          end
        end
        m_owner = next_owner;
        m_pulse = next_pulse;
      end
      @(posedge i_clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (i_nrst && pop[k]) void'(cq[k].pop_front());
      end
      pop = '0;
      for (int k = 0; k < N; k++) begin
        if (cq[k].size() > 0) begin
          i_req_valid[k] = 1'b1;
          i_req_data[k*DW +: DW] = cq[k][0][DW-1:0];
          i_req_last[k] = cq[k][0][DW];
        end else begin
          i_req_valid[k] = 1'b0;
          i_req_data[k*DW +: DW] = '0;
          i_req_last[k] = 1'b0;
        end
      end
      i_tx_ready = (rdy_mode != 0) ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  initial begin : time_limit
    #1000000;
    $display("FAIL global_timeout: bench still running at %0t, required to finish earlier", $time);
    $fatal(1, "bench time limit exceeded");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic push_byte(input int k, input logic [DW-1:0] d, input bit last);
    cq[k].push_back({last, d});
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (cq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input int budget, input string name);
    int b = 0;
    while (!(all_empty() && m_owner < 0) && b < budget) begin
      tick(1);
      b++;
    end
    n_cmp++;
    if (b >= budget) begin
      n_bad++;
      $display("FAIL %s_wait: still busy after %0d cycles, required idle", name, b);
    end
  endtask

  task automatic wait_xf(input int n, input int budget, input string name);
    int b = 0;
    while (xf_cyc.size() < n && b < budget) begin
      tick(1);
      b++;
    end
    n_cmp++;
    if (b >= budget) begin
      n_bad++;
      $display("FAIL %s_xfer_wait: %0d transfers seen, required %0d", name, xf_cyc.size(), n);
    end
  endtask

  task automatic test_reset();
    i_nrst = 1'b0;
    i_req_valid = '0; i_req_data = '0; i_req_last = '0; i_tx_ready = 1'b1;
    tick(3);
    n_cmp++; if (o_grant !== '0) begin n_bad++; $display("FAIL reset_grant got=%b required=0", o_grant); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b required=0", o_busy); end
    n_cmp++; if (o_tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got=%b required=0", o_tx_valid); end
    n_cmp++; if (o_req_ready !== '0) begin n_bad++; $display("FAIL reset_ready got=%b required=0", o_req_ready); end
    n_cmp++; if (o_timeout_pulse !== 1'b0 || o_timeout_id !== 2'd0) begin
      n_bad++; $display("FAIL reset_timeout got pulse=%b id=%0d required 0/0", o_timeout_pulse, o_timeout_id);
    end
    #1 i_nrst = 1'b1;
    tick(2);
  endtask

  task automatic test_contention();
    int s, c0;
    int e_cli [4] = '{0, 0, 2, 2};
    int e_off [4] = '{3, 4, 6, 7};
    logic [DW-1:0] e_dat [4] = '{8'hA0, 8'hA1, 8'hC0, 8'hC1};
    logic [N-1:0] e_gnt [4] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100};
    s = xf_cyc.size(); c0 = cyc;
    push_byte(0, 8'hA0, 0); push_byte(0, 8'hA1, 1);
    push_byte(2, 8'hC0, 0); push_byte(2, 8'hC1, 1);
    wait_done(60, "contention");
    n_cmp++;
    if (xf_cyc.size() != s + 4) begin
      n_bad++; $display("FAIL contention_count got=%0d required=4", xf_cyc.size() - s);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (xf_cli[s+i] != e_cli[i] || xf_dat[s+i] !== e_dat[i] || xf_cyc[s+i] != c0 + e_off[i] || xf_gnt[s+i] !== e_gnt[i]) begin
          n_bad++;
          $display("FAIL contention_byte%0d got cli=%0d dat=%h cyc=+%0d gnt=%b required cli=%0d dat=%h cyc=+%0d gnt=%b",
                   i, xf_cli[s+i], xf_dat[s+i], xf_cyc[s+i] - c0, xf_gnt[s+i], e_cli[i], e_dat[i], e_off[i], e_gnt[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    int s, c0;
    s = xf_cyc.size(); c0 = cyc;
    push_byte(1, 8'h41, 0); push_byte(1, 8'h42, 0); push_byte(1, 8'h43, 1);
    wait_done(60, "single");
    n_cmp++;
    if (xf_cyc.size() != s + 3) begin
      n_bad++; $display("FAIL single_count got=%0d required=3", xf_cyc.size() - s);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (xf_cli[s+i] != 1 || xf_dat[s+i] !== 8'(8'h41 + i) || xf_cyc[s+i] != c0 + 3 + i || xf_gnt[s+i] !== 4'b0010) begin
          n_bad++;
          $display("FAIL single_byte%0d got cli=%0d dat=%h cyc=+%0d gnt=%b required cli=1 dat=%h cyc=+%0d gnt=0010",
                   i, xf_cli[s+i], xf_dat[s+i], xf_cyc[s+i] - c0, xf_gnt[s+i], 8'(8'h41 + i), 3 + i);
        end
      end
    end
    tick(1);
    n_cmp++; if (o_grant !== '0) begin n_bad++; $display("FAIL single_grant_after got=%b required=0", o_grant); end
  endtask

  task automatic test_backpressure();
    int s, p;
    bit ok;
    s = xf_cyc.size(); p = pulse_cyc.size();
    for (int i = 0; i < 4; i++) push_byte(0, 8'(8'h10 + i), i == 3);
    wait_xf(s + 1, 40, "backpressure");
    rdy_val = 1'b0;
    tick(2000);
    rdy_val = 1'b1;
    wait_done(60, "backpressure");
    n_cmp++;
    if (pulse_cyc.size() != p) begin
      n_bad++; $display("FAIL backpressure_timeout got=%0d pulses required=0", pulse_cyc.size() - p);
    end
    n_cmp++;
    if (xf_cyc.size() != s + 4) begin
      n_bad++; $display("FAIL backpressure_count got=%0d required=4", xf_cyc.size() - s);
    end else begin
      ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (xf_cli[s+i] != 0 || xf_dat[s+i] !== 8'(8'h10 + i)) begin
          n_bad++; $display("FAIL backpressure_byte%0d got cli=%0d dat=%h required cli=0 dat=%h", i, xf_cli[s+i], xf_dat[s+i], 8'(8'h10 + i));
        end
        if (i > 0 && xf_cyc[s+i] - xf_cyc[s+i-1] >= 2000) ok = 1'b1;
      end
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL backpressure_gap got no gap >=2000 cycles, required one"); end
    end
  endtask

  task automatic test_stall();
    int s, p;
    s = xf_cyc.size(); p = pulse_cyc.size();
    push_byte(3, 8'h5A, 0);
    wait_xf(s + 1, 40, "stall");
    for (int b = 0; b < 100 && pulse_cyc.size() == p; b++) tick(1);
    n_cmp++;
    if (pulse_cyc.size() != p + 1) begin
      n_bad++; $display("FAIL stall_pulse got=%0d pulses required=1", pulse_cyc.size() - p);
    end else begin
      n_cmp++;
      if (pulse_cyc[p] - xf_cyc[xf_cyc.size()-1] != TO + 1) begin
        n_bad++; $display("FAIL stall_latency got=%0d cycles after byte required=%0d", pulse_cyc[p] - xf_cyc[xf_cyc.size()-1], TO + 1);
      end
    end
    tick(3);
    n_cmp++;
    if (o_timeout_id !== 2'd3 || o_timeout_pulse !== 1'b0 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL stall_after got id=%0d pulse=%b busy=%b required id=3 pulse=0 busy=0", o_timeout_id, o_timeout_pulse, o_busy);
    end
  endtask

  task automatic test_fairness();
    int s, c0;
    s = xf_cyc.size(); c0 = cyc;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < N; k++) push_byte(k, 8'(8'h80 + r*4 + k), 1);
    wait_done(100, "fairness");
    n_cmp++;
    if (xf_cyc.size() != s + 12) begin
      n_bad++; $display("FAIL fairness_count got=%0d required=12", xf_cyc.size() - s);
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_cmp++;
        if (xf_cli[s+i] != i % N || xf_dat[s+i] !== 8'(8'h80 + i) || xf_cyc[s+i] != c0 + 3 + 2*i) begin
          n_bad++;
          $display("FAIL fairness_msg%0d got cli=%0d dat=%h cyc=+%0d required cli=%0d dat=%h cyc=+%0d",
                   i, xf_cli[s+i], xf_dat[s+i], xf_cyc[s+i] - c0, i % N, 8'(8'h80 + i), 3 + 2*i);
        end
      end
    end
  endtask

  task automatic test_random();
    int s, p, total, k, len;
    s = xf_cyc.size(); p = pulse_cyc.size(); total = 0;
    rdy_mode = 1;
    for (int m = 0; m < 40; m++) begin
      k = $urandom_range(0, N-1);
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) push_byte(k, 8'($urandom), i == len - 1);
      total += len;
      tick($urandom_range(0, 6));
    end
    wait_done(5000, "random");
    rdy_mode = 0;
    n_cmp++;
    if (xf_cyc.size() - s != total) begin
      n_bad++; $display("FAIL random_count got=%0d required=%0d", xf_cyc.size() - s, total);
    end
    n_cmp++;
    if (pulse_cyc.size() != p) begin
      n_bad++; $display("FAIL random_timeout got=%0d pulses required=0", pulse_cyc.size() - p);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    push_byte(1, 8'h11, 1);
    wait_done(40, "reset_mid_pre");
    s = xf_cyc.size();
    for (int i = 0; i < 4; i++) push_byte(2, 8'(8'h21 + i), i == 3);
    wait_xf(s + 1, 40, "reset_mid");
    rdy_val = 1'b0;
    tick(3);
    #1 i_nrst = 1'b0;
    #1;
    n_cmp++;
    if (o_tx_valid !== 1'b0 || o_req_ready !== '0 || o_grant !== '0 || o_busy !== 1'b0 || o_tx_data !== '0 || o_timeout_id !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs got tx_valid=%b ready=%b grant=%b busy=%b data=%h id=%0d required all zero",
               o_tx_valid, o_req_ready, o_grant, o_busy, o_tx_data, o_timeout_id);
    end
    for (int k = 0; k < N; k++) cq[k].delete();
    tick(2);
    #1 i_nrst = 1'b1;
    rdy_val = 1'b1;
    tick(1);
    s = xf_cyc.size();
    push_byte(1, 8'h31, 1); push_byte(2, 8'h32, 1); push_byte(3, 8'h33, 1);
    wait_done(60, "reset_mid_post");
    n_cmp++;
    if (xf_cyc.size() != s + 3) begin
      n_bad++; $display("FAIL reset_mid_count got=%0d required=3", xf_cyc.size() - s);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (xf_cli[s+i] != i + 1 || xf_dat[s+i] !== 8'(8'h31 + i)) begin
          n_bad++; $display("FAIL reset_mid_order%0d got cli=%0d dat=%h required cli=%0d dat=%h",
                            i, xf_cli[s+i], xf_dat[s+i], i + 1, 8'(8'h31 + i));
        end
      end
    end
  endtask

  initial begin : main
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_stall();
    test_fairness();
    test_random();
    test_reset_mid();
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
